// File: rtl/r_cpu_pkg.sv
// Shared definitions for the R-type CPU sequencer and ALU: FSM encoding,
// R-type funct codes and ALU operation selects.
package r_cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_WB   = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLLV = 6'h04;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLLV = 4'd7;

    function automatic logic is_rtype(input logic [31:0] instr);
        return instr[31:26] == OP_RTYPE;
    endfunction

endpackage

// File: rtl/r_funct_decode.sv
// Combinational funct -> ALU operation decode for R-type instructions.
// Unknown funct codes report legal=0 with alu_op parked at ALU_ADD.
module r_funct_decode
    import r_cpu_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       legal
);

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_XOR:  alu_op = ALU_XOR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_SLT:  alu_op = ALU_SLT;
            FN_SLLV: alu_op = ALU_SLLV;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/r_cpu_sequencer.sv
// Multi-cycle sequencer for R-type instructions: fetch, decode, execute,
// write back, with a sticky error state for anything it cannot execute.
module r_cpu_sequencer
    import r_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        pc_inc,
    output logic [4:0]  r_addr_a,
    output logic [4:0]  r_addr_b,
    output logic [4:0]  w_addr,
    output logic        write_reg,
    output logic [3:0]  alu_op,
    output logic        busy,
    output logic        err,
    output logic [31:0] instr_count,
    output logic [2:0]  dbg_state
);

    // Handshake: imem_req is held high for every IF cycle; the cycle in which
    // imem_ack is seen high (only while in IF) transfers imem_rdata and ends
    // the fetch. There is no timeout; imem_ack outside IF is ignored.

    state_t      state_q;
    state_t      state_d;
    logic [31:0] ir_q;
    logic [31:0] count_q;
    logic [3:0]  alu_op_q;
    logic        err_q;

    logic [3:0]  dec_op;
    logic        dec_legal;
    logic        instr_ok;
    logic        unused_shamt;

    r_funct_decode u_decode (
        .funct  (ir_q[5:0]),
        .alu_op (dec_op),
        .legal  (dec_legal)
    );

    assign instr_ok     = is_rtype(ir_q) && dec_legal;
    assign unused_shamt = ^ir_q[10:6];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes are decoded from the registered state, so an asynchronous reset
    // (which forces IDLE) removes them in the same instant.
    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        pc_inc    = 1'b0;
        write_reg = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (run) state_d = S_IF;
            end
            S_IF: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    pc_inc  = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID:    state_d = instr_ok ? S_EX : S_ERR;
            S_EX:    state_d = S_WB;
            S_WB: begin
                write_reg = 1'b1;
                state_d   = run ? S_IF : S_IDLE;
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q     <= '0;
            count_q  <= '0;
            alu_op_q <= ALU_ADD;
            err_q    <= 1'b0;
        end else begin
            if (state_q == S_IF && imem_ack) ir_q <= imem_rdata;
            if (state_q == S_WB) count_q <= count_q + 32'd1;
            if (state_d == S_ERR) err_q <= 1'b1;
            // alu_op is only meaningful from EX through WB; it reads 0 elsewhere.
            case (state_d)
                S_EX:    alu_op_q <= (state_q == S_ID) ? dec_op : alu_op_q;
                S_WB:    alu_op_q <= alu_op_q;
                default: alu_op_q <= ALU_ADD;
            endcase
        end
    end

    assign r_addr_a    = ir_q[25:21];
    assign r_addr_b    = ir_q[20:16];
    assign w_addr      = ir_q[15:11];
    assign alu_op      = alu_op_q;
    assign err         = err_q;
    assign instr_count = count_q;
    assign dbg_state   = state_q;

endmodule
